// File: rtl/bsg_clk_gen_pearl_pkg.sv
// Shared types and constants for the clock generator pearl test blocks.
package bsg_clk_gen_pearl_pkg;

    typedef enum logic [1:0] {
        eIdle,
        eSettle,
        eCount,
        eDone
    } bsg_clk_gen_pearl_freq_state_e;

    localparam int unsigned bsg_clk_gen_pearl_freq_settle_gp = 3;

endpackage

// File: rtl/bsg_clk_gen_pearl_edge_counter.sv
// One watched-clock channel: two-flop synchronizer, rising-edge detect and a
// saturating edge counter with clear and enable.
module bsg_clk_gen_pearl_edge_counter #(
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     i_watch_clk,
    input  logic                     i_clear,
    input  logic                     i_en,
    output logic [count_width_p-1:0] o_count_next
);

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_prev;
    logic [count_width_p-1:0] r_count;
    logic [count_width_p-1:0] w_countNext;
    logic                     w_rise;

    assign w_rise = r_sync2 & ~r_prev;

    // The next value is exported so the parent can capture a window's final
    // count on the same edge that closes the window.
    always_comb begin
        w_countNext = r_count;
        if (i_clear) begin
            w_countNext = '0;
        end else if (i_en && w_rise && !(&r_count)) begin
            w_countNext = r_count + count_width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_watch_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_count <= w_countNext;
        end
    end

    assign o_count_next = w_countNext;

endmodule

// File: rtl/bsg_clk_gen_pearl_freq_checker.sv
// Multi-channel frequency monitor: counts watched-clock rising edges over a
// programmable window and checks each count against per-channel limits.
module bsg_clk_gen_pearl_freq_checker
    import bsg_clk_gen_pearl_pkg::*;
#(
    parameter int num_clks_p     = 1,
    parameter int window_width_p = 16,
    parameter int count_width_p  = 16
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_clks_p-1:0]               watch_clk_i,
    input  logic                                start_i,
    input  logic                                cont_i,
    input  logic                                stop_i,
    input  logic [window_width_p-1:0]           window_cycles_i,
    input  logic [num_clks_p*count_width_p-1:0] min_count_i,
    input  logic [num_clks_p*count_width_p-1:0] max_count_i,
    output logic                                v_o,
    input  logic                                ready_i,
    output logic [num_clks_p*count_width_p-1:0] count_o,
    output logic [num_clks_p-1:0]               pass_o,
    output logic                                err_o,
    output logic                                busy_o
);

    localparam int settle_w_lp = $clog2(bsg_clk_gen_pearl_freq_settle_gp);

    bsg_clk_gen_pearl_freq_state_e r_state;
    bsg_clk_gen_pearl_freq_state_e w_stateNext;

    logic [window_width_p-1:0]           r_winLen;
    logic [window_width_p-1:0]           r_winCnt;
    logic [settle_w_lp-1:0]              r_settleCnt;
    logic                                r_cont;
    logic                                r_stopPend;
    logic [num_clks_p*count_width_p-1:0] r_count;
    logic [num_clks_p-1:0]               r_pass;
    logic                                r_err;

    logic                                w_start;
    logic                                w_contGo;
    logic                                w_settleDone;
    logic                                w_lastCount;
    logic                                w_close;
    logic                                w_clear;
    logic                                w_countEn;
    logic [num_clks_p*count_width_p-1:0] w_countNext;
    logic [num_clks_p-1:0]               w_passNext;

    assign w_start      = (r_state == eIdle) && start_i;
    assign w_contGo     = (r_state == eDone) && ready_i && r_cont && !r_stopPend && !stop_i;
    assign w_settleDone = r_settleCnt == settle_w_lp'(bsg_clk_gen_pearl_freq_settle_gp - 1);
    assign w_lastCount  = r_winCnt <= window_width_p'(1);
    assign w_close      = (w_stateNext == eDone) && (r_state != eDone);
    assign w_clear      = w_start || w_contGo;
    // A zero-length window reloaded in continuous mode closes without counting.
    assign w_countEn    = (r_state == eCount) && (r_winCnt != '0);

    for (genvar n = 0; n < num_clks_p; n++) begin : g_chan
        logic [count_width_p-1:0] w_cnt;
        logic [count_width_p-1:0] w_min;
        logic [count_width_p-1:0] w_max;

        assign w_min = min_count_i[n*count_width_p +: count_width_p];
        assign w_max = max_count_i[n*count_width_p +: count_width_p];

        bsg_clk_gen_pearl_edge_counter #(
            .count_width_p(count_width_p)
        ) u_edgeCounter (
            .clk_i       (clk_i),
            .reset_i     (reset_i),
            .i_watch_clk (watch_clk_i[n]),
            .i_clear     (w_clear),
            .i_en        (w_countEn),
            .o_count_next(w_cnt)
        );

        assign w_countNext[n*count_width_p +: count_width_p] = w_cnt;
        assign w_passNext[n] = (w_cnt >= w_min) && (w_cnt <= w_max);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= eIdle;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            eIdle:   if (start_i)      w_stateNext = eSettle;
            eSettle: if (w_settleDone) w_stateNext = (r_winLen == '0) ? eDone : eCount;
            eCount:  if (w_lastCount)  w_stateNext = eDone;
            eDone:   if (ready_i)      w_stateNext = w_contGo ? eCount : eIdle;
            default:                   w_stateNext = eIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_winLen    <= '0;
            r_winCnt    <= '0;
            r_settleCnt <= '0;
            r_cont      <= 1'b0;
            r_stopPend  <= 1'b0;
            r_count     <= '0;
            r_pass      <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_start) begin
                r_winLen <= window_cycles_i;
                r_winCnt <= window_cycles_i;
                r_cont   <= cont_i;
                r_err    <= 1'b0;
            end else if (w_contGo) begin
                r_winCnt <= r_winLen;
            end else if ((r_state == eCount) && (r_winCnt != '0)) begin
                r_winCnt <= r_winCnt - window_width_p'(1);
            end

            r_settleCnt <= (r_state == eSettle) ? r_settleCnt + settle_w_lp'(1) : '0;

            if (r_state == eIdle) begin
                r_stopPend <= 1'b0;
            end else if (stop_i) begin
                r_stopPend <= 1'b1;
            end

            // Results and limits are sampled on the edge that enters eDone.
            if (w_close) begin
                r_count <= w_countNext;
                r_pass  <= w_passNext;
                if (!(&w_passNext)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign v_o     = (r_state == eDone);
    assign busy_o  = (r_state != eIdle);
    assign count_o = r_count;
    assign pass_o  = r_pass;
    assign err_o   = r_err;

endmodule

// File: tb/tb_bsg_clk_gen_pearl_freq_checker.sv
// Self-checking bench for bsg_clk_gen_pearl_freq_checker: table vectors, random
// windows against an edge-counting model, continuous mode, saturation and reset.
module tb_bsg_clk_gen_pearl_freq_checker;

    typedef struct {
        int hp0;
        int hp1;
        int w;
        int min0;
        int max0;
        int min1;
        int max1;
        int expC0;
        int expC1;
        int expPass;
        int expErr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  watch;
    logic        start, cont, stop, ready;
    logic [15:0] win;
    logic [31:0] minC, maxC;
    logic        v;
    logic [31:0] cnt;
    logic [1:0]  pass;
    logic        err, busy;

    logic        watch2, start2, cont2, stop2, ready2;
    logic [15:0] win2;
    logic [3:0]  min2, max2;
    logic        v2;
    logic [3:0]  cnt2;
    logic        pass2, err2, busy2;

    int edgeNum = 0;
    int hp [3] = '{0, 0, 0};
    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    bsg_clk_gen_pearl_freq_checker #(
        .num_clks_p(2), .window_width_p(16), .count_width_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset), .watch_clk_i(watch), .start_i(start),
        .cont_i(cont), .stop_i(stop), .window_cycles_i(win),
        .min_count_i(minC), .max_count_i(maxC), .v_o(v), .ready_i(ready),
        .count_o(cnt), .pass_o(pass), .err_o(err), .busy_o(busy)
    );

    bsg_clk_gen_pearl_freq_checker #(
        .num_clks_p(1), .window_width_p(16), .count_width_p(4)
    ) dutSat (
        .clk_i(clk), .reset_i(reset), .watch_clk_i(watch2), .start_i(start2),
        .cont_i(cont2), .stop_i(stop2), .window_cycles_i(win2),
        .min_count_i(min2), .max_count_i(max2), .v_o(v2), .ready_i(ready2),
        .count_o(cnt2), .pass_o(pass2), .err_o(err2), .busy_o(busy2)
    );

    // Cycle j is the interval following posedge number j.
    always @(posedge clk) edgeNum++;

    // A watched clock with half-period h cycles, as a function of cycle number.
    function automatic logic level(int h, int j);
        if (h == 0) return 1'b0;
        return ((j / h) % 2) == 1;
    endfunction

    // Pins change mid-cycle so the synchronizer sees each change on the next edge.
    always @(negedge clk) begin
        watch[0] = level(hp[0], edgeNum);
        watch[1] = level(hp[1], edgeNum);
        watch2   = level(hp[2], edgeNum);
    end

    // Pin rises in cycle j reach the edge detector in cycle j+2, so a window
    // whose counting cycles are a..a+w-1 sees rises from cycles a-2..a+w-3.
    function automatic int expCount(int h, int a, int w, int cw);
        int c;
        int cap;
        c = 0;
        cap = (1 << cw) - 1;
        for (int j = a - 2; j <= a + w - 3; j++) begin
            if (level(h, j) && !level(h, j - 1)) c++;
        end
        return (c > cap) ? cap : c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic doStart(input int w, input logic c, output int tAcc);
        @(negedge clk);
        win   = 16'(w);
        cont  = c;
        start = 1'b1;
        tAcc  = edgeNum;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitValid(input int budget, output int seenAt);
        seenAt = -1;
        for (int i = 0; i < budget; i++) begin
            if (v === 1'b1) begin
                seenAt = edgeNum;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input vec_t vec, input string tag);
        int t, seen, e0, e1;
        logic [1:0] ep;
        logic ee;
        hp[0] = vec.hp0;
        hp[1] = vec.hp1;
        minC = {16'(vec.min1), 16'(vec.min0)};
        maxC = {16'(vec.max1), 16'(vec.max0)};
        repeat (3) @(negedge clk);
        doStart(vec.w, 1'b0, t);
        waitValid(vec.w + 20, seen);
        e0 = (vec.expC0 >= 0) ? vec.expC0 : expCount(vec.hp0, t + 4, vec.w, 16);
        e1 = (vec.expC1 >= 0) ? vec.expC1 : expCount(vec.hp1, t + 4, vec.w, 16);
        ep[0] = (e0 >= vec.min0) && (e0 <= vec.max0);
        ep[1] = (e1 >= vec.min1) && (e1 <= vec.max1);
        if (vec.expPass >= 0) ep = 2'(vec.expPass);
        ee = (vec.expErr >= 0) ? (vec.expErr != 0) : !(&ep);
        checkOutput({tag, ".latency"}, 64'(seen), 64'(t + 4 + vec.w));
        checkOutput({tag, ".count0"}, cnt[15:0], 64'(e0));
        checkOutput({tag, ".count1"}, cnt[31:16], 64'(e1));
        checkOutput({tag, ".pass"}, pass, ep);
        checkOutput({tag, ".err"}, err, ee);
        checkOutput({tag, ".busyDone"}, busy, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checkOutput({tag, ".idleBusy"}, busy, 0);
        checkOutput({tag, ".idleValid"}, v, 0);
    endtask

    initial begin
        vec_t vecs [5];
        int t, seen, a, h, nResults, extra;

        vecs[0] = '{4, 0,  800, 99, 101, 0,  0,  100, 0,  3, 0};
        vecs[1] = '{4, 10, 400, 49, 51,  49, 51, 50,  20, 1, 1};
        vecs[2] = '{4, 10, 0,   0,  10,  5,  10, 0,   0,  1, 1};
        vecs[3] = '{4, 10, 0,   0,  0,   0,  0,  0,   0,  3, 0};
        vecs[4] = '{2, 3,  120, 30, 30,  21, 30, 30,  20, 1, 1};

        reset = 1'b1;
        start = 1'b0; cont = 1'b0; stop = 1'b0; ready = 1'b0;
        win = '0; minC = '0; maxC = '0;
        start2 = 1'b0; cont2 = 1'b0; stop2 = 1'b0; ready2 = 1'b0;
        win2 = '0; min2 = '0; max2 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.valid", v, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.err", err, 0);
        checkOutput("reset.count", cnt, 0);
        checkOutput("reset.pass", pass, 0);
        checkOutput("reset.satBusy", busy2, 0);
        checkOutput("reset.satCount", cnt2, 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            vec_t r;
            r.hp0  = int'($urandom_range(2, 12));
            r.hp1  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 12));
            r.w    = int'($urandom_range(0, 300));
            r.min0 = int'($urandom_range(0, r.w / 4 + 2));
            r.max0 = r.min0 + int'($urandom_range(0, 20));
            r.min1 = int'($urandom_range(0, r.w / 4 + 2));
            r.max1 = r.min1 + int'($urandom_range(0, 20));
            r.expC0 = -1; r.expC1 = -1; r.expPass = -1; r.expErr = -1;
            applyStimulus(r, $sformatf("rand%0d", i));
        end

        // Narrow counter saturates instead of wrapping.
        hp[2] = 2;
        repeat (3) @(negedge clk);
        win2 = 16'd200; min2 = 4'd0; max2 = 4'd15; start2 = 1'b1;
        t = edgeNum;
        @(negedge clk);
        start2 = 1'b0;
        seen = -1;
        for (int i = 0; i < 260; i++) begin
            if (v2 === 1'b1) begin
                seen = edgeNum;
                break;
            end
            @(negedge clk);
        end
        checkOutput("sat.latency", 64'(seen), 64'(t + 204));
        checkOutput("sat.count", cnt2, 15);
        checkOutput("sat.pass", pass2, 1);
        checkOutput("sat.err", err2, 0);
        ready2 = 1'b1;
        @(negedge clk);
        ready2 = 1'b0;
        checkOutput("sat.idleBusy", busy2, 0);

        // Continuous mode with stalls; first window fails, later ones pass with
        // relaxed live limits, and a stop during the third window ends the run.
        hp[0] = 3; hp[1] = 5;
        minC = {16'd0, 16'd11};
        maxC = {16'd100, 16'd20};
        repeat (3) @(negedge clk);
        doStart(60, 1'b1, t);
        a = t + 4;
        nResults = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                repeat (5) @(negedge clk);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
            end
            waitValid(100, seen);
            if (seen >= 0) nResults++;
            checkOutput($sformatf("cont%0d.latency", k), 64'(seen), 64'(a + 60));
            repeat (10) @(negedge clk);
            checkOutput($sformatf("cont%0d.stallValid", k), v, 1);
            checkOutput($sformatf("cont%0d.count0", k), cnt[15:0], 64'(expCount(3, a, 60, 16)));
            checkOutput($sformatf("cont%0d.count1", k), cnt[31:16], 64'(expCount(5, a, 60, 16)));
            checkOutput($sformatf("cont%0d.pass", k), pass, (k == 0) ? 2'b10 : 2'b11);
            checkOutput($sformatf("cont%0d.err", k), err, 1);
            if (k == 0) minC[15:0] = 16'd0;
            ready = 1'b1;
            h = edgeNum;
            @(negedge clk);
            ready = 1'b0;
            a = h + 1;
        end
        checkOutput("cont.idleBusy", busy, 0);
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (v === 1'b1) extra++;
        end
        checkOutput("cont.results", 64'(nResults + extra), 3);

        // Reset in the middle of a window drops the measurement entirely.
        hp[0] = 4; hp[1] = 10;
        repeat (3) @(negedge clk);
        doStart(500, 1'b0, t);
        repeat (100) @(negedge clk);
        checkOutput("midReset.busyBefore", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midReset.valid", v, 0);
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.err", err, 0);
        checkOutput("midReset.count", cnt, 0);
        checkOutput("midReset.pass", pass, 0);
        reset = 1'b0;
        extra = 0;
        repeat (600) begin
            @(negedge clk);
            if (v === 1'b1) extra++;
        end
        checkOutput("midReset.noResult", 64'(extra), 0);
        applyStimulus(vecs[1], "postReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/bsg_clk_gen_pearl_freq_checker.md
# bsg_clk_gen_pearl_freq_checker

Multi-channel, self-checking frequency monitor for the clock generator pearl test environment. It samples `num_clks_p` slow watched clocks (the divided `clk_monitor_o` outputs of one or more pearls) on a single reference clock. It counts rising edges of each watched clock over a programmable window and compares each count against per-channel min/max limits. Results are returned through a valid/ready handshake, in one-shot or continuous mode. It replaces ad-hoc `watch_clk` observation in the PCB-level bench and is synthesizable, so it can also sit on a gateway FPGA.

## Interface
- `num_clks_p`, 1, number of watched clock channels
- `window_width_p`, 16, width of window length in reference cycles
- `count_width_p`, 16, width of per-channel edge counters and limits
- `clk_i`  in  1  reference clock; the only clock domain
- `reset_i`  in  1  reset, synchronous, active-high
- `watch_clk_i`  in  num_clks_p  asynchronous watched clocks, bit n = channel n
- `start_i`  in  1  pulse; begins a measurement when idle
- `cont_i`  in  1  continuous mode, sampled with `start_i`
- `stop_i`  in  1  ends continuous mode after the current window
- `window_cycles_i`  in  window_width_p  window length W, sampled with `start_i`
- `min_count_i`  in  num_clks_p*count_width_p  lower limits, channel n at [n*count_width_p +: count_width_p]
- `max_count_i`  in  num_clks_p*count_width_p  upper limits, same packing
- `v_o`  out  1  result valid
- `ready_i`  in  1  result accepted
- `count_o`  out  num_clks_p*count_width_p  edge counts of the last window
- `pass_o`  out  num_clks_p  per-channel `min <= count <= max`
- `err_o`  out  1  sticky: any channel failed in any window since the last accepted `start_i`
- `busy_o`  out  1  state != eIdle

## Operation
- Each channel has a two-flop synchronizer followed by a previous-sample register. A rising edge is `sync & ~prev`.
- The synchronizer and edge registers update in every state; counting happens only in eCount.
- Watched clocks must stay high and low for at least 2 `clk_i` cycles each. Faster inputs undercount, and this is not flagged.
- States:
  - eIdle: `start_i` latches W and `cont_i`, clears counters and `err_o`, and goes to eSettle.
  - eSettle: 3 cycles to flush the synchronizers, then eCount. If W==0, go straight to eDone with all counts 0.
  - eCount: the window counter decrements each cycle. Each channel counter increments on a detected edge and saturates at all-ones, with no wrap. After W cycles, the state goes to eDone and the counts and pass bits are registered.
  - eDone: `v_o`=1. `count_o` and `pass_o` stay stable until `v_o & ready_i`. On handshake:
    - if continuous mode is active and no stop is pending: clear counters, reload W, go to eCount (no re-settle; edges during eDone are not counted);
    - otherwise go to eIdle.
- `stop_i` in any non-idle state sets a stop-pending flag, which is cleared in eIdle. `stop_i` in eIdle is ignored.
- `start_i` outside eIdle is ignored. Limits are read live when the window closes.
- `err_o` is set when a result with any `pass_o` bit = 0 enters eDone.
- `reset_i` at any time: return to eIdle and clear all registers; no result is produced.

## Timing
- Reset values:
  - `v_o`=0, `busy_o`=0, `err_o`=0
  - `count_o`=0
  - `pass_o`=0
  - state eIdle
  - synchronizer and edge registers = 0
- If `start_i` is accepted at cycle t:
  - eSettle occupies t+1..t+3;
  - eCount occupies t+4..t+3+W;
  - `v_o` rises at t+4+W.
- If W==0, `v_o` rises at t+4.
- An edge at the pin is seen by the edge detector 2–3 cycles later.
- In continuous mode, a handshake at cycle h starts the next eCount at h+1, and the next `v_o` rises at h+1+W.
- `v_o & ready_i` in the same cycle as `stop_i` with continuous mode set: go to eIdle.

## Structure
- Add to `bsg_clk_gen_pearl_pkg`:
  - the `bsg_clk_gen_pearl_freq_state_e` enum (eIdle, eSettle, eCount, eDone);
  - the settle-length constant `bsg_clk_gen_pearl_freq_settle_gp` = 3.
- Sub-module `bsg_clk_gen_pearl_edge_counter`, instantiated once per channel: synchronizer, edge detect, and a saturating counter with clear and enable.
- The top level holds the FSM, window counter, comparators, and output registers.

## Test plan
- Channel 0 toggles every 4 cycles (period 8); W=800; min=99, max=101; start -> `v_o` at t+804, count=100 (±1), `pass_o[0]`=1, `err_o`=0.
- Two channels, periods 8 and 20; W=400; limits 50±1 for both -> counts 50 and 20, `pass_o`=2'b01, `err_o`=1.
- `count_width_p`=4; period 4; W=200 -> count saturates at 15 with no wrap.
- W=0 -> `v_o` at t+4, counts 0, `pass_o` equals `min==0` per channel.
- Continuous mode with `ready_i` held low 10 cycles each window, then `stop_i` during the third window -> exactly 3 results, `count_o` stable while stalled, then eIdle.
- `reset_i` asserted mid-eCount -> next cycle all outputs are at reset values and no `v_o`; a fresh start then measures correctly.
